hazard_ctrl: RTL and testbench

//  Pipeline hazard controller; generates stall/flush for the F/D and D/X latches
//  and PC. Detects load-use hazards, flushes on taken branches, and freezes the

---
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller. It stalls on load-use, flushes on a
//            taken branch, and freezes the front end for mult/div with a
//            bounded wait. Define HAZARD_PERF_EN to build the perf counters.
// Revision : 1.0
//==============================================================================
module hazard_ctrl #(
   parameter int REG_W      = 5,
   parameter int MD_TIMEOUT = 40,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic             d_uses_rt,
   input  logic             x_is_load,
   input  logic [REG_W-1:0] x_rd,
   input  logic             x_branch_taken,
   input  logic             x_md_start,
   input  logic             md_ready,
   output logic             pc_stall,
   output logic             fd_stall,
   output logic             fd_flush,
   output logic             dx_flush,
   output logic             md_busy,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = $clog2(MD_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              load_use;

   assign load_use = x_is_load && (x_rd != '0) &&
                     ((x_rd == d_rs) || (d_uses_rt && (x_rd == d_rt)));

   // Control outputs act in the same cycle as the hazard they respond to.
   always_comb begin
      pc_stall = 1'b0;
      fd_stall = 1'b0;
      fd_flush = 1'b0;
      dx_flush = 1'b0;
      md_busy  = 1'b0;
      if (reset) begin
         fd_flush = 1'b1;
         dx_flush = 1'b1;
      end else if (state == MD_WAIT) begin
         md_busy  = 1'b1;
         pc_stall = 1'b1;
         fd_stall = 1'b1;
         dx_flush = 1'b1;
      end else if (x_branch_taken) begin
         fd_flush = 1'b1;
         dx_flush = 1'b1;
      end else if (x_md_start || load_use) begin
         pc_stall = 1'b1;
         fd_stall = 1'b1;
         dx_flush = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= RUN;
         wait_cnt   <= '0;
         md_timeout <= 1'b0;
      end else begin
         md_timeout <= 1'b0;
         case (state)
            RUN: begin
               if (!x_branch_taken && x_md_start) begin
                  state    <= MD_WAIT;
                  wait_cnt <= '0;
               end
            end
            MD_WAIT: begin
               // A ready result on the last allowed cycle is a normal exit.
               if (md_ready) begin
                  state <= RUN;
               end else if (wait_cnt == WAIT_LAST) begin
                  state      <= RUN;
                  md_timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (fd_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl with a behavioural model.
// Revision : 1.0
//==============================================================================
module tb_hazard_ctrl;

   localparam int  MD_TO = 40;
   localparam longint MAXC = (64'd1 << 16) - 1;

   logic        clock, reset;
   logic [4:0]  d_rs, d_rt, x_rd;
   logic        d_uses_rt, x_is_load, x_branch_taken, x_md_start, md_ready;
   logic        pc_stall, fd_stall, fd_flush, dx_flush, md_busy, md_timeout;
   logic [15:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   bit     m_md = 0;
   int     m_waited = 0;
   bit     m_to = 0;
   longint m_stall = 0, m_flush = 0;

   hazard_ctrl #(.REG_W(5), .MD_TIMEOUT(MD_TO), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
      .d_uses_rt(d_uses_rt), .x_is_load(x_is_load), .x_rd(x_rd),
      .x_branch_taken(x_branch_taken), .x_md_start(x_md_start),
      .md_ready(md_ready), .pc_stall(pc_stall), .fd_stall(fd_stall),
      .fd_flush(fd_flush), .dx_flush(dx_flush), .md_busy(md_busy),
      .md_timeout(md_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // {pc_stall, fd_stall, fd_flush, dx_flush, md_busy} from the hazard rules
   function automatic logic [4:0] exp_ctl();
      bit lu;
      lu = x_is_load && x_rd != 0 && (x_rd == d_rs || (d_uses_rt && x_rd == d_rt));
      if (reset)          return 5'b00110;
      if (m_md)           return 5'b11011;
      if (x_branch_taken) return 5'b00110;
      if (x_md_start || lu) return 5'b11010;
      return 5'b00000;
   endfunction

   always @(posedge clock) begin
      logic [4:0] e;
      e = exp_ctl();
      if (reset) begin
         m_md = 0; m_waited = 0; m_to = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (e[4] && m_stall < MAXC) m_stall++;
         if (e[2] && m_flush < MAXC) m_flush++;
         m_to = 0;
         if (m_md) begin
            m_waited++;
            if (md_ready) m_md = 0;
            else if (m_waited == MD_TO) begin m_md = 0; m_to = 1; end
         end else if (!x_branch_taken && x_md_start) begin
            m_md = 1; m_waited = 0;
         end
      end
   end

   always @(negedge clock) begin
      logic [4:0] e;
      e = exp_ctl();
      chk("pc_stall", pc_stall, e[4]);
      chk("fd_stall", fd_stall, e[3]);
      chk("fd_flush", fd_flush, e[2]);
      chk("dx_flush", dx_flush, e[1]);
      chk("md_busy", md_busy, e[0]);
      chk("md_timeout", md_timeout, m_to);
`ifdef HAZARD_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
`else
      chk("stall_cnt", stall_cnt, 0);
      chk("flush_cnt", flush_cnt, 0);
`endif
   end

   task automatic cyc(); @(posedge clock); #1; endtask
   task automatic mid(); @(negedge clock); #1; endtask

   task automatic idle();
      d_rs = 0; d_rt = 0; x_rd = 0; d_uses_rt = 0; x_is_load = 0;
      x_branch_taken = 0; x_md_start = 0; md_ready = 0;
   endtask

   task automatic load(input int rd, input int rs, input int rt, input bit urt);
      idle();
      x_is_load = 1; x_rd = 5'(rd); d_rs = 5'(rs); d_rt = 5'(rt); d_uses_rt = urt;
   endtask

   initial begin
      int n_pc, n_busy, n_to;
      reset = 1; idle();
      mid();
      chk("rst_fd_flush", fd_flush, 1); chk("rst_dx_flush", dx_flush, 1);
      chk("rst_pc_stall", pc_stall, 0); chk("rst_md_busy", md_busy, 0);
      cyc(); cyc();
      reset = 0; mid();
      chk("idle_pc_stall", pc_stall, 0); chk("idle_dx_flush", dx_flush, 0);
      cyc();

      // load-use via rs, one cycle only
      load(5, 5, 0, 0); mid();
      chk("lu_pc", pc_stall, 1); chk("lu_fd", fd_stall, 1); chk("lu_dx", dx_flush, 1);
      cyc(); idle(); mid(); chk("lu_after_pc", pc_stall, 0);
      cyc();
      load(0, 0, 0, 0); mid(); chk("lu_r0", pc_stall, 0); cyc();
      load(7, 3, 7, 0); mid(); chk("lu_rt_unused", pc_stall, 0); cyc();
      load(7, 3, 7, 1); mid(); chk("lu_rt_used", pc_stall, 1); cyc();
      load(9, 9, 9, 1); mid(); chk("lu_both", pc_stall, 1); cyc();
      // branch beats a simultaneous load-use
      load(5, 5, 0, 0); x_branch_taken = 1; mid();
      chk("br_fd_flush", fd_flush, 1); chk("br_dx_flush", dx_flush, 1);
      chk("br_pc_stall", pc_stall, 0); cyc();
      idle(); x_branch_taken = 1; x_md_start = 1; mid();
      chk("br_md_pc", pc_stall, 0); cyc();
      idle(); mid();
      chk("br_md_ignored", md_busy, 0);
`ifdef HAZARD_PERF_EN
      chk("perf_stall3", stall_cnt, 3); chk("perf_flush2", flush_cnt, 2);
`endif
      cyc();

      // mult/div with ready on the fifth wait cycle
      n_pc = 0; n_busy = 0; n_to = 0;
      for (int i = 0; i < 10; i++) begin
         idle(); x_md_start = (i == 0); md_ready = (i == 5);
         mid(); n_pc += pc_stall; n_busy += md_busy; n_to += md_timeout;
         cyc();
      end
      chk("md5_pc_cycles", n_pc, 6); chk("md5_busy_cycles", n_busy, 5);
      chk("md5_no_timeout", n_to, 0);

      // mult/div that never completes
      n_pc = 0; n_busy = 0; n_to = 0;
      for (int i = 0; i < 50; i++) begin
         idle(); x_md_start = (i == 0);
         mid(); n_pc += pc_stall; n_busy += md_busy; n_to += md_timeout;
         cyc();
      end
      chk("to_busy_cycles", n_busy, 40); chk("to_pc_cycles", n_pc, 41);
      chk("to_pulses", n_to, 1); chk("to_back_in_run", md_busy, 0);

      // reset in the middle of a wait
      for (int i = 0; i < 4; i++) begin idle(); x_md_start = (i == 0); cyc(); end
      mid(); chk("pre_rst_busy", md_busy, 1); cyc();
      reset = 1; mid(); chk("rst_mid_busy", md_busy, 0); chk("rst_mid_pc", pc_stall, 0);
      cyc(); reset = 0; mid();
      chk("post_rst_busy", md_busy, 0); chk("post_rst_stall_cnt", stall_cnt, 0);
      chk("post_rst_flush_cnt", flush_cnt, 0); chk("post_rst_to", md_timeout, 0);
      cyc();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 299) == 0);
         d_rs           = 5'($urandom_range(0, 3));
         d_rt           = 5'($urandom_range(0, 3));
         x_rd           = 5'($urandom_range(0, 3));
         d_uses_rt      = 1'($urandom_range(0, 1));
         x_is_load      = ($urandom_range(0, 2) == 0);
         x_branch_taken = ($urandom_range(0, 7) == 0);
         x_md_start     = ($urandom_range(0, 15) == 0);
         md_ready       = ($urandom_range(0, 59) == 0);
         cyc();
      end
      idle(); reset = 0;
      mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
